// File: rtl/perf_pkg.sv
// Shared definitions for the performance-counter MMIO responder: FSM states,
// CTRL register layout, counter index map and the default bank size.
// Pure declarations; no logic, latency or backpressure of its own.
package perf_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } perf_state_e;

  // CTRL register sits just above the 16 possible counter slots.
  localparam logic [7:0] CTRL_OFFSET = 8'h80;

  localparam int CTRL_FREEZE_BIT    = 0;
  localparam int CTRL_CLEAR_ALL_BIT = 1;

  // Index order of the counter bank as wired into ctr_values.
  localparam int PERF_I_STALL    = 0;
  localparam int PERF_D_STALL    = 1;
  localparam int PERF_L2_STALL   = 2;
  localparam int PERF_BRANCH     = 3;
  localparam int PERF_MISPREDICT = 4;
  localparam int PERF_STALL      = 5;

  localparam int PERF_NUM_CTRS_DEFAULT = 6;

endpackage

// File: rtl/perf_mmio_decode.sv
// Address decoder for the counter window: window hit and register classification.
// Purely combinational, zero latency; no flow control.
// Ports: address in; hit, ctr_idx, hi_sel, is_ctrl, is_unmapped out.
module perf_mmio_decode
  import perf_pkg::*;
#(
  parameter int          NUM_CTRS  = PERF_NUM_CTRS_DEFAULT,
  parameter logic [31:0] ADDR_BASE = 32'hFFFF_FF00
) (
  input  logic [31:0] address,
  output logic        hit,
  output logic [3:0]  ctr_idx,
  output logic        hi_sel,
  output logic        is_ctrl,
  output logic        is_unmapped
);

  logic [7:0] offset;
  logic       is_ctr;

  // The window is 256-byte aligned, so the offset is just the low byte.
  assign offset  = address[7:0];
  assign hit     = (address[31:8] == ADDR_BASE[31:8]);
  assign ctr_idx = offset[6:3];
  assign hi_sel  = offset[2];
  assign is_ctrl = (offset == CTRL_OFFSET);

  // Counter slots need word alignment and an index that exists in this bank.
  assign is_ctr      = !offset[7] && (offset[1:0] == 2'b00) &&
                       (32'(offset[6:3]) < NUM_CTRS);
  assign is_unmapped = !is_ctr && !is_ctrl;

endmodule

// File: rtl/perf_counter_reader.sv
// MMIO responder exposing the perf counter bank; atomic 64-bit reads via hi shadows.
// Latency: request sampled at edge N, mem_resp/mem_rdata/ctr_clear valid in cycle N+1.
// Backpressure: master holds the request until mem_resp; at most one access per 2 cycles.
// Ports: clk/rst_n; ctr_values in; mem_read/mem_write/mem_address/mem_wdata/
//        mem_byte_enable in; hit, mem_rdata, mem_resp, ctr_clear, ctr_freeze out.
// Optional feature: define PERF_CTR_FREEZE_EN to implement CTRL.FREEZE / ctr_freeze.
module perf_counter_reader
  import perf_pkg::*;
#(
  parameter int          NUM_CTRS  = PERF_NUM_CTRS_DEFAULT,
  parameter int          CTR_WIDTH = 32,
  parameter logic [31:0] ADDR_BASE = 32'hFFFF_FF00
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_CTRS*CTR_WIDTH-1:0] ctr_values,
  input  logic                          mem_read,
  input  logic                          mem_write,
  input  logic [31:0]                   mem_address,
  input  logic [31:0]                   mem_wdata,
  input  logic [3:0]                    mem_byte_enable,
  output logic                          hit,
  output logic [31:0]                   mem_rdata,
  output logic                          mem_resp,
  output logic [NUM_CTRS-1:0]           ctr_clear,
  output logic                          ctr_freeze
);

  perf_state_e           state, state_n;
  logic [3:0]            ctr_idx;
  logic                  hi_sel, is_ctrl, is_unmapped;
  logic [63:0]           sel_val;
  logic [31:0]           sel_shadow;
  logic [NUM_CTRS*32-1:0] hi_shadow;
  logic [31:0]           rdata_q, rdata_n;
  logic [NUM_CTRS-1:0]   clr_q, clr_n;
  logic                  shadow_we;
  logic                  ctrl_wr;
  logic                  freeze_q;
  logic                  unused_bits;

  perf_mmio_decode #(
    .NUM_CTRS  (NUM_CTRS),
    .ADDR_BASE (ADDR_BASE)
  ) u_decode (
    .address     (mem_address),
    .hit         (hit),
    .ctr_idx     (ctr_idx),
    .hi_sel      (hi_sel),
    .is_ctrl     (is_ctrl),
    .is_unmapped (is_unmapped)
  );

  // Selected counter zero-extended to 64 bits, so a 32-bit bank yields a zero high word.
  always_comb begin
    sel_val    = '0;
    sel_shadow = '0;
    for (int i = 0; i < NUM_CTRS; i++) begin
      if (4'(i) == ctr_idx) begin
        sel_val[CTR_WIDTH-1:0] = ctr_values[i*CTR_WIDTH +: CTR_WIDTH];
        sel_shadow             = hi_shadow[i*32 +: 32];
      end
    end
  end

  always_comb begin
    state_n   = state;
    rdata_n   = '0;
    clr_n     = '0;
    shadow_we = 1'b0;
    ctrl_wr   = 1'b0;
    case (state)
      IDLE: begin
        if (hit && (mem_read || mem_write)) begin
          state_n = RESP;
          // Read wins when both strobes are up.
          if (mem_read) begin
            if (is_ctrl) begin
              rdata_n = {31'b0, freeze_q};
            end else if (!is_unmapped) begin
              rdata_n   = hi_sel ? sel_shadow : sel_val[31:0];
              shadow_we = !hi_sel;
            end
          end else if (mem_byte_enable != 4'b0000) begin
            if (is_ctrl) begin
              ctrl_wr = mem_byte_enable[0];
              if (ctrl_wr && mem_wdata[CTRL_CLEAR_ALL_BIT]) clr_n = '1;
            end else if (!is_unmapped && !hi_sel) begin
              for (int i = 0; i < NUM_CTRS; i++) clr_n[i] = (4'(i) == ctr_idx);
            end
          end
        end
      end
      RESP:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // rdata/clear are re-registered every cycle, so they are zero outside RESP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rdata_q   <= '0;
      clr_q     <= '0;
      hi_shadow <= '0;
    end else begin
      state   <= state_n;
      rdata_q <= rdata_n;
      clr_q   <= clr_n;
      if (shadow_we) begin
        for (int i = 0; i < NUM_CTRS; i++) begin
          if (4'(i) == ctr_idx) hi_shadow[i*32 +: 32] <= sel_val[63:32];
        end
      end
    end
  end

`ifdef PERF_CTR_FREEZE_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      freeze_q <= 1'b0;
    end else if (ctrl_wr) begin
      freeze_q <= mem_wdata[CTRL_FREEZE_BIT];
    end
  end
  assign unused_bits = ^mem_wdata[31:2];
`else
  assign freeze_q    = 1'b0;
  assign unused_bits = ^{mem_wdata[31:2], mem_wdata[CTRL_FREEZE_BIT]};
`endif

  assign mem_resp   = (state == RESP);
  assign mem_rdata  = rdata_q;
  assign ctr_clear  = clr_q;
  assign ctr_freeze = freeze_q;

endmodule
